// File: rtl/instr_fetch_assembler.sv
// Jolt160 front end: fetches halfwords over a req/ack bus, queues them and presents
// whole instructions (one halfword, or two for group 5). Prefetch is enabled by JOLT160_FETCH_PREFETCH_EN.
module instr_fetch_assembler #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] instr_hi,
    output logic [15:0] instr_lo,
    output logic        instr_wide,
    output logic        instr_unknown,
    output logic [15:0] instr_pc
);

`ifdef JOLT160_FETCH_PREFETCH_EN
    localparam int QD = FIFO_DEPTH;
`else
    // FIFO_DEPTH is at least 2, so this is always the fixed two-entry queue.
    localparam int QD = (FIFO_DEPTH < 2) ? FIFO_DEPTH : 2;
`endif
    localparam int PW = $clog2(QD);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} fstate_t;
    typedef enum logic [2:0] {G1, G2, G3, G4, G5, GUNK} grp_t;

    function automatic grp_t classify(input logic [15:0] h);
        grp_t g;
        casez (h[15:10])
            6'b0?????: g = G1;
            6'b10????: g = G2;
            6'b1100??: g = G3;
            6'b1101??: g = G4;
            6'b111000: g = G5;
            default:   g = GUNK;
        endcase
        return g;
    endfunction

    fstate_t         state, state_nxt;
    logic [15:0]     fetch_pc, req_addr, head_pc;
    logic [15:0]     q_mem [QD];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_nxt, pop_cnt;
    logic [15:0]     head, second;
    grp_t            head_grp;
    logic            head_present, head_wide, head_complete;
    logic            can_fetch, push, pop, req_c;

    assign head         = q_mem[rd_ptr];
    assign second       = q_mem[rd_ptr + PW'(1)];
    assign head_grp     = classify(head);
    assign head_present = (count != '0);
    assign head_wide    = (head_grp == G5);
    assign head_complete = head_present && (!head_wide || count >= CW'(2));

`ifdef JOLT160_FETCH_PREFETCH_EN
    assign can_fetch = (count < CW'(QD));
`else
    // Stop once the current instruction is whole; never run ahead of the decoder.
    assign can_fetch = !head_complete && (count < CW'(QD));
`endif

    assign push    = (state == REQ) && mem_ack && !redirect;
    assign pop     = head_complete && out_ready && !redirect;
    assign pop_cnt = pop ? (head_wide ? CW'(2) : CW'(1)) : '0;
    assign count_nxt = count + CW'(push) - pop_cnt;

    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_fetch && !redirect) begin
                    state_nxt = REQ;
                    req_c     = 1'b1;
                end
            end
            REQ: begin
                req_c = 1'b1;
                if (mem_ack)       state_nxt = IDLE;
                else if (redirect) state_nxt = DISCARD;
            end
            DISCARD: begin
                req_c = 1'b1;
                if (mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The IDLE request is combinational, so keep it quiet while reset is held.
    assign mem_req  = req_c & rst_n;
    assign mem_addr = (state == IDLE) ? fetch_pc : req_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == REQ) req_addr <= fetch_pc;
            if (redirect)  fetch_pc <= redirect_addr;
            else if (push) fetch_pc <= fetch_pc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head_pc <= RESET_PC;
        end else if (redirect) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head_pc <= redirect_addr;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + (head_wide ? PW'(2) : PW'(1));
                head_pc <= head_pc + (head_wide ? 16'd2 : 16'd1);
            end
            count <= count_nxt;
        end
    end

    // Storage is not reset; everything read from it is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= mem_rdata;
    end

    assign out_valid     = head_complete;
    assign instr_hi      = head_present ? head : 16'h0000;
    assign instr_lo      = (head_complete && head_wide) ? second : 16'h0000;
    assign instr_wide    = head_present && head_wide;
    assign instr_unknown = head_present && (head_grp == GUNK);
    assign instr_pc      = head_pc;

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Scoreboard bench for instr_fetch_assembler: a memory responder serves a halfword image,
// expected instructions are queued as stimulus is set up and checked at each handshake.
module tb_instr_fetch_assembler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_ack;
    logic [15:0] mem_addr, mem_rdata;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        out_valid, out_ready;
    logic [15:0] instr_hi, instr_lo, instr_pc;
    logic        instr_wide, instr_unknown;

    instr_fetch_assembler #(.RESET_PC(16'h0100), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_hi(instr_hi), .instr_lo(instr_lo), .instr_wide(instr_wide),
        .instr_unknown(instr_unknown), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

`ifdef JOLT160_FETCH_PREFETCH_EN
    localparam int EXP_ACC = 4;
`else
    localparam int EXP_ACC = 1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        wide;
        logic        unk;
        logic [15:0] pc;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input logic [15:0] hi, input logic [15:0] lo,
                            input logic wide, input logic unk, input logic [15:0] pc);
        exp_t e;
        e.hi = hi; e.lo = lo; e.wide = wide; e.unk = unk; e.pc = pc;
        sb.push_back(e);
    endtask

    // Memory image and responder: ack after lat cycles of a held request.
    logic [15:0] img [logic [15:0]];
    int lat = 1;
    int cnt = 0;
    int acc03 = 0;

    function automatic logic [15:0] rd_img(input logic [15:0] a);
        return img.exists(a) ? img[a] : 16'h0001;
    endfunction

    initial begin
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk); #2;
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = (mem_req && rst_n) ? 1 : 0;
            end else if (mem_req && rst_n) begin
                if (cnt >= lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd_img(mem_addr);
                    if (mem_addr[15:8] == 8'h03) acc03++;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Handshake monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("instr_hi", instr_hi, e.hi);
                    chk("instr_lo", instr_lo, e.lo);
                    chk("wide_unk", {instr_wide, instr_unknown}, {e.wide, e.unk});
                    chk("instr_pc", instr_pc, e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_redirect(input logic [15:0] a);
        tick();
        redirect = 1'b1;
        redirect_addr = a;
        tick();
        redirect = 1'b0;
    endtask

    task automatic drain(input int limit, input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < limit && sb.size() != 0; i++) tick();
        chk(tag, sb.size(), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        img[16'h0100] = 16'h3A55; img[16'h0101] = 16'hE0D3;
        img[16'h0102] = 16'h1234; img[16'h0103] = 16'hF000;
        img[16'h0300] = 16'h0A00; img[16'h0301] = 16'h8001;
        img[16'h0302] = 16'hC002; img[16'h0303] = 16'hD003;
        img[16'h0304] = 16'hE404; img[16'h0305] = 16'h7FFF;
        img[16'h0306] = 16'hBFFF; img[16'h0307] = 16'hF800;
        img[16'h0105] = 16'h1111;
        img[16'h2000] = 16'h4321; img[16'h2001] = 16'hE123; img[16'h2002] = 16'h5678;
        img[16'hFFFF] = 16'hE000; img[16'h0000] = 16'h00AA;
        img[16'h0001] = 16'h0042; img[16'h0002] = 16'hE3FF; img[16'h0003] = 16'hABCD;

        rst_n = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 16'h0100);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_instr_hi", instr_hi, 0);
        chk("rst_instr_lo", instr_lo, 0);
        chk("rst_wide_unk", {instr_wide, instr_unknown}, 0);
        chk("rst_instr_pc", instr_pc, 16'h0100);

        rst_n = 1'b1;
        #2;
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 16'h0100);

        // First ack: head visible the following cycle, fetch pointer advanced.
        for (int i = 0; i < 10 && !mem_ack; i++) tick();
        chk("ack1_seen", mem_ack, 1);
        chk("ack1_out_valid", out_valid, 1);
        chk("ack1_instr_hi", instr_hi, 16'h3A55);
        chk("ack1_wide_lo", {instr_wide, instr_lo}, 0);
        chk("ack1_instr_pc", instr_pc, 16'h0100);
        chk("ack1_next_addr", mem_addr, 16'h0101);
`ifndef JOLT160_FETCH_PREFETCH_EN
        chk("ack1_no_prefetch", mem_req, 0);
`endif
        push_exp(16'h3A55, 16'h0000, 1'b0, 1'b0, 16'h0100);
        push_exp(16'hE0D3, 16'h1234, 1'b1, 1'b0, 16'h0101);
        push_exp(16'hF000, 16'h0000, 1'b0, 1'b1, 16'h0103);
        drain(200, "drain_basic");

        // Fill with the decoder stalled, then drain in order.
        acc03 = 0;
        do_redirect(16'h0300);
        #1;
        chk("redir_out_valid", out_valid, 0);
        repeat (40) tick();
        chk("fill_acks", acc03, EXP_ACC);
        chk("fill_req_idle", mem_req, 0);
        push_exp(16'h0A00, 16'h0000, 1'b0, 1'b0, 16'h0300);
        push_exp(16'h8001, 16'h0000, 1'b0, 1'b0, 16'h0301);
        push_exp(16'hC002, 16'h0000, 1'b0, 1'b0, 16'h0302);
        push_exp(16'hD003, 16'h0000, 1'b0, 1'b0, 16'h0303);
        push_exp(16'hE404, 16'h0000, 1'b0, 1'b1, 16'h0304);
        push_exp(16'h7FFF, 16'h0000, 1'b0, 1'b0, 16'h0305);
        push_exp(16'hBFFF, 16'h0000, 1'b0, 1'b0, 16'h0306);
        push_exp(16'hF800, 16'h0000, 1'b0, 1'b1, 16'h0307);
        drain(300, "drain_fill");

        // Redirect while the request at 0105 is outstanding; its data must be dropped.
        lat = 3;
        do_redirect(16'h0105);
        #1;
        for (int i = 0; i < 30 && !(mem_req && mem_addr == 16'h0105); i++) tick();
        chk("req_0105", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0105});
        tick();
        redirect = 1'b1;
        redirect_addr = 16'h2000;
        tick();
        redirect = 1'b0;
        #1;
        chk("discard_out_valid", out_valid, 0);
        chk("discard_hold", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0105});
        for (int i = 0; i < 20 && !(mem_req && mem_addr == 16'h2000); i++) tick();
        chk("req_2000", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h2000});
        lat = 1;
        push_exp(16'h4321, 16'h0000, 1'b0, 1'b0, 16'h2000);
        push_exp(16'hE123, 16'h5678, 1'b1, 1'b0, 16'h2001);
        drain(200, "drain_redirect");

        // Wide instruction straddling the 16-bit address wrap.
        do_redirect(16'hFFFF);
        push_exp(16'hE000, 16'h00AA, 1'b1, 1'b0, 16'hFFFF);
        push_exp(16'h0042, 16'h0000, 1'b0, 1'b0, 16'h0001);
        push_exp(16'hE3FF, 16'hABCD, 1'b1, 1'b0, 16'h0002);
        drain(200, "drain_wrap");

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
